// File: rtl/zvs_deadtime_driver_if.sv
// rtl/zvs_deadtime_driver_if.sv - command/status bundle for the ZVS dead-time gate driver
interface zvs_deadtime_driver_if #(
    parameter int DT_W = 8
) ();
    logic            EN;
    logic            PWM_IN;
    logic [DT_W-1:0] DEAD_TIME;
    logic            FAULT;
    logic            FAULT_CLR;
    logic            GATE_HI;
    logic            GATE_LO;
    logic            FAULT_LATCHED;
    logic [15:0]     HI_PULSES;

    // Controller side: issues commands, observes the gates.
    modport master (
        output EN, PWM_IN, DEAD_TIME, FAULT, FAULT_CLR,
        input  GATE_HI, GATE_LO, FAULT_LATCHED, HI_PULSES
    );

    // Driver side.
    modport slave (
        input  EN, PWM_IN, DEAD_TIME, FAULT, FAULT_CLR,
        output GATE_HI, GATE_LO, FAULT_LATCHED, HI_PULSES
    );
endinterface

// File: rtl/zvs_deadtime_driver.sv
// rtl/zvs_deadtime_driver.sv - half-bridge gate driver with dead-time insertion and fault latch
module zvs_deadtime_driver #(
    parameter int DT_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    zvs_deadtime_driver_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DEAD  = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t          state;
    logic            pwm_s;
    logic [DT_W-1:0] dt_cnt;
    logic [DT_W-1:0] dt_load;
    logic            gate_hi;
    logic            gate_lo;
    logic            fault_latched;
    logic [15:0]     hi_pulses;

    // A zero dead time still forces one cycle with both gates off.
    assign dt_load = (bus.DEAD_TIME == '0) ? DT_W'(1) : bus.DEAD_TIME;

    // State, dead counter and gate registers; gates only ever rise out of DEAD so they cannot overlap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            pwm_s         <= 1'b0;
            dt_cnt        <= '0;
            gate_hi       <= 1'b0;
            gate_lo       <= 1'b0;
            fault_latched <= 1'b0;
            hi_pulses     <= '0;
        end else begin
            pwm_s <= bus.PWM_IN;
            if (bus.FAULT) begin
                state         <= FAULT;
                gate_hi       <= 1'b0;
                gate_lo       <= 1'b0;
                fault_latched <= 1'b1;
            end else begin
                case (state)
                    FAULT: begin
                        if (bus.FAULT_CLR) begin
                            state         <= IDLE;
                            fault_latched <= 1'b0;
                        end
                    end
                    IDLE: begin
                        if (bus.EN) begin
                            state  <= DEAD;
                            dt_cnt <= dt_load;
                        end
                    end
                    DEAD: begin
                        if (!bus.EN) begin
                            state  <= IDLE;
                            dt_cnt <= '0;
                        end else if (dt_cnt <= DT_W'(1)) begin
                            dt_cnt <= '0;
                            if (pwm_s) begin
                                state     <= HI;
                                gate_hi   <= 1'b1;
                                hi_pulses <= hi_pulses + 16'd1;
                            end else begin
                                state   <= LO;
                                gate_lo <= 1'b1;
                            end
                        end else begin
                            dt_cnt <= dt_cnt - DT_W'(1);
                        end
                    end
                    HI: begin
                        if (!bus.EN) begin
                            state   <= IDLE;
                            gate_hi <= 1'b0;
                        end else if (!pwm_s) begin
                            state   <= DEAD;
                            gate_hi <= 1'b0;
                            dt_cnt  <= dt_load;
                        end
                    end
                    LO: begin
                        if (!bus.EN) begin
                            state   <= IDLE;
                            gate_lo <= 1'b0;
                        end else if (pwm_s) begin
                            state   <= DEAD;
                            gate_lo <= 1'b0;
                            dt_cnt  <= dt_load;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        gate_hi <= 1'b0;
                        gate_lo <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.GATE_HI       = gate_hi;
    assign bus.GATE_LO       = gate_lo;
    assign bus.FAULT_LATCHED = fault_latched;
    assign bus.HI_PULSES     = hi_pulses;
endmodule

// File: doc/zvs_deadtime_driver.md
ZVS_DEADTIME_DRIVER -- requirements
Module: zvs_deadtime_driver

Interface
REQ-001 Parameter DT_W, default 8, sets the width of the dead-time count.
REQ-002 Port CLK, input, 1 bit, the single clock; all state changes on posedge CLK.
REQ-003 Port RST, input, 1 bit, is an asynchronous, active-high reset.
REQ-004 Port EN, input, 1 bit, enables gate switching; when low, both gates are off.
REQ-005 Port PWM_IN, input, 1 bit, is the PWM command from the upstream PWM stage in the same CLK domain; 1 requests high-side on, 0 requests low-side on.
REQ-006 Port DEAD_TIME, input, DT_W bits, is the dead time in CLK cycles; it is sampled on entry to a dead interval.
REQ-007 Port FAULT, input, 1 bit, is a synchronous fault request (overcurrent/desat).
REQ-008 Port FAULT_CLR, input, 1 bit, clears a latched fault.
REQ-009 Port GATE_HI, output, 1 bit, is the registered high-side gate drive.
REQ-010 Port GATE_LO, output, 1 bit, is the registered low-side gate drive.
REQ-011 Port FAULT_LATCHED, output, 1 bit, is high while the block is in FAULT.
REQ-012 Port HI_PULSES, output, 16 bits, counts entries into state HI and wraps.

Function
REQ-013 PWM_IN SHALL be registered once into pwm_s; all decisions SHALL use pwm_s.
REQ-014 The FSM SHALL have exactly the states IDLE, DEAD, HI, LO and FAULT.
REQ-015 GATE_HI SHALL be 1 only in HI and GATE_LO SHALL be 1 only in LO; both outputs SHALL come from the registered state, with no combinational path from any input.
REQ-016 GATE_HI and GATE_LO SHALL never both be 1 in any cycle, including during and after reset.
REQ-017 IDLE -> DEAD SHALL occur when EN=1.
REQ-018 On entry to DEAD, the count SHALL load max(DEAD_TIME,1); the count SHALL decrement each cycle in DEAD; DEAD SHALL therefore last exactly max(DEAD_TIME,1) cycles.
REQ-019 When the DEAD count expires, the FSM SHALL go to HI if pwm_s=1, else to LO; pwm_s SHALL be evaluated in the final DEAD cycle, so a PWM_IN change during DEAD SHALL NOT restart the count.
REQ-020 HI -> DEAD SHALL occur when pwm_s=0, and LO -> DEAD SHALL occur when pwm_s=1.
REQ-021 A stable PWM_IN edge before posedge n SHALL turn off the active gate after posedge n+1 and turn on the opposite gate after posedge n+1+max(DEAD_TIME,1).
REQ-022 EN=0 SHALL move any non-FAULT state to IDLE on the next edge, with both gates 0 after that edge.
REQ-023 FAULT=1 at an edge SHALL move to FAULT from any state, with highest priority over EN and pwm_s; both gates SHALL be 0 and FAULT_LATCHED SHALL be 1 after that edge.
REQ-024 FAULT -> IDLE SHALL occur only when FAULT_CLR=1 and FAULT=0 at the same edge; FAULT_CLR while FAULT=1 SHALL be ignored.
REQ-025 FAULT -> IDLE followed by EN=1 SHALL always pass through a full DEAD interval before either gate turns on.
REQ-026 HI_PULSES SHALL increment by 1 on each transition into HI and wrap from 16'hFFFF to 0; it SHALL hold in all other cases.
REQ-027 A DEAD_TIME change while in HI or LO SHALL take effect at the next DEAD entry only.

Reset
REQ-028 RST=1 SHALL force, asynchronously: state IDLE, GATE_HI=0, GATE_LO=0, FAULT_LATCHED=0, HI_PULSES=0, dead count=0, pwm_s=0.
REQ-029 Reset asserted in HI or LO SHALL turn both gates off immediately, without waiting for a clock edge.
REQ-030 After RST falls with EN=1, the first gate turn-on SHALL follow a full DEAD interval.

Verification
REQ-031 Basic switching: EN=1, DEAD_TIME=5, PWM_IN toggling every 20 cycles -> GATE_LO falls 2 edges after the PWM_IN rise and GATE_HI rises exactly 5 cycles later; the mirror timing holds on the PWM_IN fall; GATE_HI&GATE_LO=0 in every cycle.
REQ-032 Zero dead time: DEAD_TIME=0 -> both gates are off for exactly 1 cycle at every transition.
REQ-033 Glitch absorbed: DEAD_TIME=8 in LO; PWM_IN pulses high for 3 cycles -> DEAD lasts 8 cycles, then the FSM returns to LO and HI_PULSES is unchanged.
REQ-034 Fault: FAULT pulsed in HI -> both gates 0 and FAULT_LATCHED=1 next edge; FAULT_CLR with FAULT=1 -> stays in FAULT; FAULT_CLR with FAULT=0 -> IDLE, then a full DEAD interval before a gate turns on.
REQ-035 Async reset: RST asserted mid-cycle in HI -> GATE_HI=0 before the next edge; HI_PULSES=0.
REQ-036 Counter wrap: preload 65535 HI entries (or force the count) and enter HI once more -> HI_PULSES=0.
